// File: rtl/relogio_pkg.sv
// Shared definitions for the wall-clock controller: set-state encoding, BCD digit type,
// field limits and a two-digit BCD increment helper.
package relogio_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef struct packed {
    logic carry;
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // Wraps to 00 with carry once the pair reaches max; otherwise plain BCD increment.
  function automatic bcd2_t bcd2_inc(input bcd_t tens, input bcd_t ones, input int max);
    bcd2_t r;
    r.carry = 1'b0;
    r.tens  = tens;
    r.ones  = ones + 4'd1;
    if (tens == bcd_t'(max / 10) && ones == bcd_t'(max % 10)) begin
      r.carry = 1'b1;
      r.tens  = 4'd0;
      r.ones  = 4'd0;
    end else if (ones == 4'd9) begin
      r.tens = tens + 4'd1;
      r.ones = 4'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/relogio_set_controller_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce counter and a
// one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             level, level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/relogio_set_controller.sv
// HH:MM:SS time-keeping controller with a two-button set procedure.
// Optional digit blinking while editing is enabled by defining RELOGIO_BLINK_EN.
module relogio_set_controller
  import relogio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] set_state,
  output logic [3:0] blank_mask
);

  logic mode_ev, inc_ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .press (mode_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .press (inc_ev)
  );

  bcd2_t      sec_c, min_c, hr_c;
  logic [1:0] state_nxt;
  bcd_t       ht_nxt, ho_nxt, mt_nxt, mo_nxt, st_nxt, so_nxt;

  always_comb begin
    sec_c     = bcd2_inc(sec_tens, sec_ones, SEC_MAX);
    min_c     = bcd2_inc(min_tens, min_ones, MIN_MAX);
    hr_c      = bcd2_inc(hour_tens, hour_ones, HOUR_MAX);
    state_nxt = set_state;
    ht_nxt    = hour_tens;
    ho_nxt    = hour_ones;
    mt_nxt    = min_tens;
    mo_nxt    = min_ones;
    st_nxt    = sec_tens;
    so_nxt    = sec_ones;
    // mode always takes priority; in SET states an inc pre-empts the tick.
    case (set_state)
      ST_RUN: begin
        if (mode_ev) begin
          state_nxt = ST_SET_HOUR;
          st_nxt    = 4'd0;
          so_nxt    = 4'd0;
        end else if (tick_1hz) begin
          st_nxt = sec_c.tens;
          so_nxt = sec_c.ones;
          if (sec_c.carry) begin
            mt_nxt = min_c.tens;
            mo_nxt = min_c.ones;
            if (min_c.carry) begin
              ht_nxt = hr_c.tens;
              ho_nxt = hr_c.ones;
            end
          end
        end
      end
      ST_SET_HOUR: begin
        if (mode_ev) begin
          state_nxt = ST_SET_MIN;
        end else if (inc_ev) begin
          ht_nxt = hr_c.tens;
          ho_nxt = hr_c.ones;
        end
      end
      ST_SET_MIN: begin
        if (mode_ev) begin
          state_nxt = ST_RUN;
        end else if (inc_ev) begin
          mt_nxt = min_c.tens;
          mo_nxt = min_c.ones;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_state <= ST_RUN;
      hour_tens <= 4'd0;
      hour_ones <= 4'd0;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
    end else begin
      set_state <= state_nxt;
      hour_tens <= ht_nxt;
      hour_ones <= ho_nxt;
      min_tens  <= mt_nxt;
      min_ones  <= mo_nxt;
      sec_tens  <= st_nxt;
      sec_ones  <= so_nxt;
    end
  end

`ifdef RELOGIO_BLINK_EN
  logic phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
    end else if (state_nxt != set_state) begin
      phase <= 1'b0;
    end else if (set_state != ST_RUN && inc_ev) begin
      phase <= 1'b0;
    end else if (set_state != ST_RUN && tick_1hz) begin
      phase <= ~phase;
    end
  end

  assign blank_mask = (set_state == ST_SET_HOUR) ? {phase, phase, 2'b00} :
                      (set_state == ST_SET_MIN)  ? {2'b00, phase, phase} : 4'b0000;
`else
  assign blank_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_relogio_set_controller.sv
// Directed bench for relogio_set_controller with a short debounce window.
module tb_relogio_set_controller;

  localparam int DEB = 4;
`ifdef RELOGIO_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [3:0]  ht, ho, mt, mo, st, so, blank_mask;
  logic [1:0]  set_state;
  logic [23:0] t;
  int          checks = 0;
  int          errors = 0;

  assign t = {ht, ho, mt, mo, st, so};

  always #5 clk = ~clk;

  relogio_set_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hour_tens  (ht),
    .hour_ones  (ho),
    .min_tens   (mt),
    .min_ones   (mo),
    .sec_tens   (st),
    .sec_ones   (so),
    .set_state  (set_state),
    .blank_mask (blank_mask)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (7) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (7) step();
  endtask

  task automatic press_inc_n(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (t !== 24'h000000) begin errors++; $display("FAIL reset_time: got %h want %h", t, 24'h000000); end
    checks++;
    if (set_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", set_state); end
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask: got %b want 0000", blank_mask); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_run_rollover();
    tick_1hz = 1'b1;
    for (int i = 1; i <= 86400; i++) begin
      step();
      if (i == 3600) begin
        checks++;
        if (t !== 24'h010000) begin errors++; $display("FAIL run_3600: got %h want %h", t, 24'h010000); end
      end
      if (i == 86399) begin
        checks++;
        if (t !== 24'h235959) begin errors++; $display("FAIL run_235959: got %h want %h", t, 24'h235959); end
      end
    end
    tick_1hz = 1'b0;
    checks++;
    if (t !== 24'h000000) begin errors++; $display("FAIL run_wrap: got %h want %h", t, 24'h000000); end
  endtask

  task automatic test_set_procedure();
    press(1'b1, 1'b0);
    press_inc_n(12);
    press(1'b1, 1'b0);
    press_inc_n(34);
    press(1'b1, 1'b0);
    tick_1hz = 1'b1;
    repeat (56) step();
    tick_1hz = 1'b0;
    checks++;
    if (t !== 24'h123456) begin errors++; $display("FAIL setup_123456: got %h want %h", t, 24'h123456); end
    press(1'b1, 1'b0);
    checks++;
    if (set_state !== 2'd1) begin errors++; $display("FAIL enter_set_hour: got %0d want 1", set_state); end
    checks++;
    if (t !== 24'h123400) begin errors++; $display("FAIL sec_cleared: got %h want %h", t, 24'h123400); end
    press_inc_n(13);
    checks++;
    if (t !== 24'h013400) begin errors++; $display("FAIL hour_wrap: got %h want %h", t, 24'h013400); end
    press(1'b1, 1'b0);
    checks++;
    if (set_state !== 2'd2) begin errors++; $display("FAIL enter_set_min: got %0d want 2", set_state); end
    press_inc_n(27);
    checks++;
    if (t !== 24'h010100) begin errors++; $display("FAIL min_wrap: got %h want %h", t, 24'h010100); end
    press(1'b1, 1'b0);
    checks++;
    if (set_state !== 2'd0) begin errors++; $display("FAIL back_to_run: got %0d want 0", set_state); end
    tick_once();
    checks++;
    if (t !== 24'h010101) begin errors++; $display("FAIL first_tick: got %h want %h", t, 24'h010101); end
  endtask

  task automatic test_set_min_wrap();
    press(1'b1, 1'b0);
    press_inc_n(9);
    press(1'b1, 1'b0);
    press_inc_n(58);
    checks++;
    if (t !== 24'h105900) begin errors++; $display("FAIL setup_1059: got %h want %h", t, 24'h105900); end
    press(1'b0, 1'b1);
    checks++;
    if (t !== 24'h100000) begin errors++; $display("FAIL min_no_carry: got %h want %h", t, 24'h100000); end
    tick_1hz = 1'b1;
    repeat (100) step();
    tick_1hz = 1'b0;
    checks++;
    if (t !== 24'h100000) begin errors++; $display("FAIL set_ticks_frozen: got %h want %h", t, 24'h100000); end
    tick_1hz = 1'b1;
    press(1'b0, 1'b1);
    tick_1hz = 1'b0;
    checks++;
    if (t !== 24'h100100) begin errors++; $display("FAIL tick_with_inc: got %h want %h", t, 24'h100100); end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      btn_inc = ((k / 2) % 2) == 0;
      step();
    end
    btn_inc = 1'b1;
    repeat (10) step();
    btn_inc = 1'b0;
    repeat (8) step();
    checks++;
    if (t !== 24'h100200) begin errors++; $display("FAIL bounce_single: got %h want %h", t, 24'h100200); end
    btn_inc = 1'b1;
    repeat (3) step();
    btn_inc = 1'b0;
    repeat (10) step();
    checks++;
    if (t !== 24'h100200) begin errors++; $display("FAIL short_pulse: got %h want %h", t, 24'h100200); end
  endtask

  task automatic test_mode_inc_same();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press_inc_n(19);
    checks++;
    if (t !== 24'h050200) begin errors++; $display("FAIL setup_05: got %h want %h", t, 24'h050200); end
    press(1'b1, 1'b1);
    checks++;
    if (set_state !== 2'd2) begin errors++; $display("FAIL both_state: got %0d want 2", set_state); end
    checks++;
    if (t !== 24'h050200) begin errors++; $display("FAIL both_time: got %h want %h", t, 24'h050200); end
  endtask

  task automatic test_blink();
    tick_once();
    checks++;
    if (blank_mask !== (BLINK ? 4'b0011 : 4'b0000)) begin
      errors++; $display("FAIL blink_min: got %b want %b", blank_mask, (BLINK ? 4'b0011 : 4'b0000));
    end
    press(1'b1, 1'b0);
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL blink_run: got %b want 0000", blank_mask); end
    press(1'b1, 1'b0);
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL blink_enter: got %b want 0000", blank_mask); end
    tick_once();
    checks++;
    if (blank_mask !== (BLINK ? 4'b1100 : 4'b0000)) begin
      errors++; $display("FAIL blink_hr1: got %b want %b", blank_mask, (BLINK ? 4'b1100 : 4'b0000));
    end
    tick_once();
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL blink_hr2: got %b want 0000", blank_mask); end
    tick_once();
    checks++;
    if (blank_mask !== (BLINK ? 4'b1100 : 4'b0000)) begin
      errors++; $display("FAIL blink_hr3: got %b want %b", blank_mask, (BLINK ? 4'b1100 : 4'b0000));
    end
    press(1'b0, 1'b1);
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL blink_inc: got %b want 0000", blank_mask); end
    checks++;
    if (t !== 24'h060200) begin errors++; $display("FAIL blink_time: got %h want %h", t, 24'h060200); end
    press(1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    checks++;
    if (set_state !== 2'd2) begin errors++; $display("FAIL pre_reset_state: got %0d want 2", set_state); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (t !== 24'h000000) begin errors++; $display("FAIL async_rst_time: got %h want %h", t, 24'h000000); end
    checks++;
    if (set_state !== 2'd0) begin errors++; $display("FAIL async_rst_state: got %0d want 0", set_state); end
    checks++;
    if (blank_mask !== 4'b0000) begin errors++; $display("FAIL async_rst_mask: got %b want 0000", blank_mask); end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_run_rollover();
    test_set_procedure();
    test_set_min_wrap();
    test_bounce();
    test_mode_inc_same();
    test_blink();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
